// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM single-port RAM arbiter.
// Tags identify which requester owns each read travelling through the RAM.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_RAM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_MEM  = 2'd2
    } arb_tag_t;

    // A taken branch turns any fetch tag into an empty slot; data tags pass untouched.
    function automatic arb_tag_t flush_tag(input arb_tag_t tag, input logic flush);
        arb_tag_t res;
        if (flush && (tag == TAG_IF)) begin
            res = TAG_NONE;
        end else begin
            res = tag;
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Ownership tags for reads in flight: RAM_LAT+1 stages, scrubbed of fetch tags on flush.
// tag_ret lines up with ram_q; tag_out lines up with the cycle the valid pulse is seen.
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RAM_LAT = DEF_RAM_LAT
) (
    input  logic     clk,
    input  logic     rst,
    input  arb_tag_t tag_in,
    input  logic     flush_if,
    output arb_tag_t tag_ret,
    output arb_tag_t tag_out
);

    localparam int DEPTH = RAM_LAT + 1;

    arb_tag_t stage_r [DEPTH];

    // Advance every tag one stage per cycle, dropping fetch tags on a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= TAG_NONE;
            end
        end else begin
            stage_r[0] <= flush_tag(tag_in, flush_if);
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= flush_tag(stage_r[i-1], flush_if);
            end
        end
    end

    // Same-cycle masking so a flush also kills the fetch at ram_q and the one about to pulse valid
    always_comb begin
        tag_ret = flush_tag(stage_r[RAM_LAT-1], flush_if);
        tag_out = flush_tag(stage_r[RAM_LAT], flush_if);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// One single-port RAM shared by instruction fetch and data memory access.
// MEM has priority; IF is forced through after STARVE_MAX consecutive losses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RAM_LAT    = DEF_RAM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_cnt_r;
    logic              if_gnt_s;
    logic              mem_gnt_s;
    arb_tag_t          issue_tag_s;
    arb_tag_t          ret_tag_s;
    arb_tag_t          out_tag_s;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] mem_rdata_r;

    // Grant decision: MEM first, IF when alone or when starved; nothing during reset or to IF on flush
    always_comb begin
        if_gnt_s  = 1'b0;
        mem_gnt_s = 1'b0;
        if (rst) begin
            if_gnt_s  = 1'b0;
            mem_gnt_s = 1'b0;
        end else begin
            if_gnt_s  = if_req & ~if_flush & (~mem_req | (starve_cnt_r == STARVE_LIM));
            mem_gnt_s = mem_req & ~if_gnt_s;
        end
    end

    // RAM port follows the winner; with no grant the fetch address is presented
    always_comb begin
        if (mem_gnt_s) begin
            ram_addr = mem_addr;
        end else begin
            ram_addr = if_addr;
        end
    end

    assign ram_wdata = mem_wdata;
    assign ram_wren  = mem_gnt_s & mem_we;
    assign if_gnt    = if_gnt_s;
    assign mem_gnt   = mem_gnt_s;
    assign if_stall  = ~rst & if_req & ~if_gnt_s;

    // Tag for the access issued this cycle; stores never return data
    always_comb begin
        if (if_gnt_s) begin
            issue_tag_s = TAG_IF;
        end else if (mem_gnt_s && !mem_we) begin
            issue_tag_s = TAG_MEM;
        end else begin
            issue_tag_s = TAG_NONE;
        end
    end

    // Count MEM wins while IF waits; any IF win or an idle IF resets the run
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (if_gnt_s || !if_req) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (mem_gnt_s && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    arb_tag_pipe #(
        .RAM_LAT (RAM_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (issue_tag_s),
        .flush_if (if_flush),
        .tag_ret  (ret_tag_s),
        .tag_out  (out_tag_s)
    );

    // Capture returning RAM data into the owner's hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_r  <= {DATA_W{1'b0}};
            mem_rdata_r <= {DATA_W{1'b0}};
        end else begin
            case (ret_tag_s)
                TAG_IF:  if_rdata_r  <= ram_q;
                TAG_MEM: mem_rdata_r <= ram_q;
                default: begin
                    if_rdata_r  <= if_rdata_r;
                    mem_rdata_r <= mem_rdata_r;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_r;
    assign mem_rdata = mem_rdata_r;
    assign if_valid  = (out_tag_s == TAG_IF);
    assign mem_valid = (out_tag_s == TAG_MEM);

endmodule
